// File: rtl/voting_pio_ctrl_if.sv
// Register-bus interface for voting_pio_ctrl: zero-wait-state slave, a write
// happens on any clock edge that samples chipselect=1 and write_n=0; reads are combinational.
interface voting_pio_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/voting_pio_ctrl.sv
// Parallel I/O port with direction, interrupt mask and edge-capture registers.
// Optional macro VOTING_PIO_BITSET_EN adds atomic set (addr 4) / clear (addr 5) of the data register.
module voting_pio_ctrl #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_OUT = 32'd0,
    parameter bit          EDGE_POL  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    voting_pio_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic [WIDTH-1:0]   out_port,
    output logic [WIDTH-1:0]   oe,
    output logic               irq
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] rd_w;
    logic             wr;
    logic             unused_ok;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wdata     = bus.writedata[WIDTH-1:0];
    assign unused_ok = &{1'b0, bus.writedata};

    // s3 holds the previous synchronized sample, so an edge is a change between s3 and s2.
    assign edge_det = EDGE_POL ? (s2_q & ~s3_q) : (~s2_q & s3_q);

    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        clr    = '0;
        if (wr) begin
            case (bus.address)
                3'd0: data_d = wdata;
                3'd1: dir_d  = wdata;
                3'd2: mask_d = wdata;
                3'd3: clr    = wdata;
`ifdef VOTING_PIO_BITSET_EN
                3'd4: data_d = data_q | wdata;
                3'd5: data_d = data_q & ~wdata;
`endif
                default: ;
            endcase
        end
        s1_d = in_port;
        s2_d = s1_q;
        s3_d = s2_q;
        // A fresh edge takes priority over a simultaneous write-1-to-clear.
        edge_d = (edge_q & ~clr) | edge_det;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_OUT[WIDTH-1:0];
            dir_q  <= '0;
            mask_q <= '0;
            edge_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
        end
    end

    always_comb begin
        rd_w = '0;
        case (bus.address)
            3'd0: rd_w = (data_q & dir_q) | (s2_q & ~dir_q);
            3'd1: rd_w = dir_q;
            3'd2: rd_w = mask_q;
            3'd3: rd_w = edge_q;
            default: rd_w = '0;
        endcase
    end

    assign bus.readdata = 32'(rd_w);
    assign out_port     = data_q;
    assign oe           = dir_q;
    assign irq          = |(edge_q & mask_q);

endmodule
